// File: rtl/uart_defs_pkg.sv
// Shared definitions for the memory-mapped UART.
// Contents:
//   - default register byte addresses (TXD, RXD, CON)
//   - CON bit indices
//   - the 2-bit state encoding used by both the TX and RX FSMs
//   - con_word(): assembles the 32-bit CON read value from its flag bits
package uart_defs;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_IE   = 0;
  localparam int CON_RX_IE   = 1;
  localparam int CON_TX_DONE = 2;
  localparam int CON_RX_DONE = 3;
  localparam int CON_TX_BUSY = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] con_word(input logic tx_busy,
                                           input logic rx_done,
                                           input logic tx_done,
                                           input logic rx_ie,
                                           input logic tx_ie);
    logic [31:0] w;
    w              = '0;
    w[CON_TX_IE]   = tx_ie;
    w[CON_RX_IE]   = rx_ie;
    w[CON_TX_DONE] = tx_done;
    w[CON_RX_DONE] = rx_done;
    w[CON_TX_BUSY] = tx_busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rxd          raw serial input, asynchronous to clk
//   rx_byte      last correctly framed byte
//   rx_strobe    one-cycle pulse when rx_byte has just been updated
// The line goes through a two-flop synchroniser. A falling edge starts a
// half-bit wait; if the line is high again at that point, it was a glitch.
// Otherwise, data bits are sampled every DIVISOR cycles, near mid-bit. A byte
// whose stop bit reads low is discarded without a strobe.
module uart_rx_core
  import uart_defs::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe
);

  localparam int               CNT_W    = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIVISOR / 2 - 1);

  logic [1:0]       sync_q, sync_d;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             strobe_q, strobe_d;
  logic             rxd_s;

  assign rxd_s     = sync_q[1];
  assign rx_byte   = byte_q;
  assign rx_strobe = strobe_q;

  // NOTE: every output of this block gets a default first. Without the
  // defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    sync_d   = {sync_q[0], rxd};
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxd_s) begin
            byte_d   = shift_q;
            strobe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b11;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART on the data-memory bus.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   MemRead, MemWrite    bus strobes
//   Address              byte address, compared in full against TXD/RXD/CON
//   Write_data           write data; only [7:0] is used
//   Read_data            combinational read data; zero when not selected
//   uart_rxd, uart_txd   serial lines; uart_txd idles high
//   irq                  level interrupt: (tx_done & tx_ie) | (rx_done & rx_ie)
// Register map (offsets from BASE_ADDR):
//   +0 TXD   +4 RXD   +8 CON = {tx_busy, rx_done, tx_done, rx_ie, tx_ie}
// A read of CON clears both done flags, and a read of RXD clears rx_done.
// If hardware sets a done flag in the same cycle as the read, the set wins.
module uart_mmio_peripheral
  import uart_defs::*;
#(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = UART_TXD_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);

  localparam int               DIVISOR  = CLK_FREQ / BAUD;
  localparam int               CNT_W    = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [31:0]      RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0]      CON_ADDR = BASE_ADDR + 32'd8;

  // Address decode and bus strobes
  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;

  assign sel_txd = (Address == BASE_ADDR);
  assign sel_rxd = (Address == RXD_ADDR);
  assign sel_con = (Address == CON_ADDR);
  assign wr_txd  = MemWrite & sel_txd;
  assign wr_con  = MemWrite & sel_con;
  assign rd_rxd  = MemRead & sel_rxd;
  assign rd_con  = MemRead & sel_con;

  logic unused_wdata;
  assign unused_wdata = ^Write_data[31:8];

  // Registers
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       txd_q, txd_d;
  logic             line_q, line_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             tx_ie_q, tx_ie_d;
  logic             rx_ie_q, rx_ie_d;
  logic             tx_done_q, tx_done_d;
  logic             rx_done_q, rx_done_d;
  logic             tx_done_set;
  logic             tx_busy;
  logic [2:0]       next_bit;

  logic [7:0]       rx_byte;
  logic             rx_strobe;

  uart_rx_core #(
    .DIVISOR(DIVISOR)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe)
  );

  assign tx_busy  = (tx_state_q != ST_IDLE);
  assign uart_txd = line_q;
  assign irq      = (tx_done_q & tx_ie_q) | (rx_done_q & rx_ie_q);
  assign next_bit = tx_bit_q + 3'd1;

  // Read mux: no register stage, valid in the same cycle as MemRead
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (sel_txd)      Read_data = {24'h0, txd_q};
      else if (sel_rxd) Read_data = {24'h0, rxd_q};
      else if (sel_con) Read_data = con_word(tx_busy, rx_done_q, tx_done_q, rx_ie_q, tx_ie_q);
    end
  end

  // TX FSM. The line is registered, so a TXD write pulls it low on the
  // same edge that starts the frame. A TXD write while busy is ignored.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    txd_d       = txd_q;
    line_d      = line_q;
    tx_done_set = 1'b0;

    unique case (tx_state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        if (wr_txd) begin
          txd_d      = Write_data[7:0];
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          line_d     = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_DATA;
          line_d     = txd_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = next_bit;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            line_d     = 1'b1;
          end else begin
            line_d = txd_q[next_bit];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = ST_IDLE;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // CON / RXD register updates; a hardware set wins over a read-clear
  always_comb begin
    tx_ie_d = tx_ie_q;
    rx_ie_d = rx_ie_q;
    if (wr_con) begin
      tx_ie_d = Write_data[CON_TX_IE];
      rx_ie_d = Write_data[CON_RX_IE];
    end

    tx_done_d = tx_done_q;
    if (rd_con)      tx_done_d = 1'b0;
    if (tx_done_set) tx_done_d = 1'b1;

    rx_done_d = rx_done_q;
    if (rd_con || rd_rxd) rx_done_d = 1'b0;
    if (rx_strobe)        rx_done_d = 1'b1;

    rxd_d = rx_strobe ? rx_byte : rxd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      txd_q      <= '0;
      line_q     <= 1'b1;
      rxd_q      <= '0;
      tx_ie_q    <= 1'b0;
      rx_ie_q    <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      line_q     <= line_d;
      rxd_q      <= rxd_d;
      tx_ie_q    <= tx_ie_d;
      rx_ie_q    <= rx_ie_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
    end
  end

endmodule
